// File: rtl/cpu_params_rv_pkg.sv
// Shared RV32I execution-stage parameters, ALU function codes and bus payload types.
package cpu_params_RV;

  localparam int unsigned RSZ      = 32;
  localparam int unsigned GPR_ASZ  = 5;
  localparam int unsigned PC_SZ    = 32;
  localparam int unsigned ALU_FSZ  = 4;
  localparam int unsigned TAG_SZ   = 4;
  localparam int unsigned INSTR_SZ = 32;

  localparam logic [ALU_FSZ-1:0] ALU_ADD     = ALU_FSZ'(0);
  localparam logic [ALU_FSZ-1:0] ALU_SUB     = ALU_FSZ'(1);
  localparam logic [ALU_FSZ-1:0] ALU_SLL     = ALU_FSZ'(2);
  localparam logic [ALU_FSZ-1:0] ALU_SLT     = ALU_FSZ'(3);
  localparam logic [ALU_FSZ-1:0] ALU_SLTU    = ALU_FSZ'(4);
  localparam logic [ALU_FSZ-1:0] ALU_XOR     = ALU_FSZ'(5);
  localparam logic [ALU_FSZ-1:0] ALU_SRL     = ALU_FSZ'(6);
  localparam logic [ALU_FSZ-1:0] ALU_SRA     = ALU_FSZ'(7);
  localparam logic [ALU_FSZ-1:0] ALU_OR      = ALU_FSZ'(8);
  localparam logic [ALU_FSZ-1:0] ALU_AND     = ALU_FSZ'(9);
  localparam logic [ALU_FSZ-1:0] ALU_PASS_Y  = ALU_FSZ'(10);
  localparam logic [ALU_FSZ-1:0] ALU_ADD_PC4 = ALU_FSZ'(11);

  localparam logic [1:0] SEL_X_RS1  = 2'd0;
  localparam logic [1:0] SEL_X_PC   = 2'd1;
  localparam logic [1:0] SEL_X_ZERO = 2'd2;
  localparam logic       SEL_Y_RS2  = 1'b0;
  localparam logic       SEL_Y_IMM  = 1'b1;

  // imm arrives from decode already sign-extended to the full data width
  typedef struct packed {
    logic [1:0]         Sel_x;
    logic               Sel_y;
    logic [ALU_FSZ-1:0] F;
    logic [RSZ-1:0]     imm;
  } Micro_Data;

  typedef struct packed {
    logic [GPR_ASZ-1:0] Rs1;
    logic [GPR_ASZ-1:0] Rs2;
    logic [GPR_ASZ-1:0] Rd;
  } Gpr_Regs;

  typedef struct packed {
    logic wr_Rd;
  } Gpr_Rw;

  typedef struct packed {
    Gpr_Regs regs;
    Gpr_Rw   regs_rw;
  } Reg_Data;

  typedef struct packed {
    logic [INSTR_SZ-1:0] instruction;
    logic [PC_SZ-1:0]    pc;
  } IP_Data;

  typedef struct packed {
    logic [TAG_SZ-1:0] tag;
    Micro_Data         md;
    Reg_Data           rd;
    IP_Data            ipd;
    logic [RSZ-1:0]    Rs1Data;
    logic [RSZ-1:0]    Rs2Data;
  } FU_Data_In;

  typedef struct packed {
    logic [TAG_SZ-1:0]  tag;
    logic [GPR_ASZ-1:0] Rd;
    logic               wr_Rd;
    logic [RSZ-1:0]     RdData;
  } FU_Data_Out;

  typedef struct packed {
    logic               valid;
    logic [GPR_ASZ-1:0] Rd;
    logic [RSZ-1:0]     RdData;
  } FWD_Data;

  function automatic logic [RSZ-1:0] zext_pc(input logic [PC_SZ-1:0] pc);
    return RSZ'(pc);
  endfunction

endpackage

// File: rtl/alu_functional_unit_core.sv
// Combinational RV32I integer ALU: result = F(x, y).
module alu_core
  import cpu_params_RV::*;
(
  input  logic [RSZ-1:0]     x,
  input  logic [RSZ-1:0]     y,
  input  logic [ALU_FSZ-1:0] F,
  output logic [RSZ-1:0]     result
);

  localparam int unsigned SHW = $clog2(RSZ);

  logic [SHW-1:0] shamt;

  always_comb begin
    shamt  = y[SHW-1:0];
    result = '0;
    case (F)
      ALU_ADD:     result = x + y;
      ALU_SUB:     result = x - y;
      ALU_SLL:     result = x << shamt;
      ALU_SLT:     result = RSZ'($signed(x) < $signed(y));
      ALU_SLTU:    result = RSZ'(x < y);
      ALU_XOR:     result = x ^ y;
      ALU_SRL:     result = x >> shamt;
      ALU_SRA:     result = $unsigned($signed(x) >>> shamt);
      ALU_OR:      result = x | y;
      ALU_AND:     result = x & y;
      ALU_PASS_Y:  result = y;
      ALU_ADD_PC4: result = x + RSZ'(4);
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_functional_unit.sv
// Integer ALU execution stage: operand select, one-deep result register with
// valid/ready handshake, and a forwarding copy of the held result.
module alu_functional_unit
  import cpu_params_RV::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  FU_Data_In  data_in,
  input  logic       valid_in,
  output logic       rdy_out,
  output FU_Data_Out data_out,
  output logic       valid_out,
  input  logic       rdy_in,
  output FWD_Data    fwd_data_out
);

  logic [RSZ-1:0] x;
  logic [RSZ-1:0] y;
  logic [RSZ-1:0] result;
  FU_Data_Out     out_q;
  logic           valid_q;
  logic           accept;
  logic           unused_fields;

  // ADD_PC4 always links from the pc, whatever Sel_x says
  always_comb begin
    x = '0;
    if (data_in.md.F == ALU_ADD_PC4) begin
      x = zext_pc(data_in.ipd.pc);
    end else begin
      case (data_in.md.Sel_x)
        SEL_X_RS1: x = data_in.Rs1Data;
        SEL_X_PC:  x = zext_pc(data_in.ipd.pc);
        default:   x = '0;
      endcase
    end
    y = (data_in.md.Sel_y == SEL_Y_IMM) ? data_in.md.imm : data_in.Rs2Data;
  end

  alu_core u_alu_core (
    .x      (x),
    .y      (y),
    .F      (data_in.md.F),
    .result (result)
  );

  assign rdy_out = !valid_q || rdy_in;
  assign accept  = valid_in && rdy_out;

  // Load on accept (also covers drain+accept); on a bare drain keep data, drop the write
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      valid_q      <= 1'b1;
      out_q.tag    <= data_in.tag;
      out_q.Rd     <= data_in.rd.regs.Rd;
      out_q.wr_Rd  <= data_in.rd.regs_rw.wr_Rd && (data_in.rd.regs.Rd != '0);
      out_q.RdData <= result;
    end else if (valid_q && rdy_in) begin
      valid_q     <= 1'b0;
      out_q.wr_Rd <= 1'b0;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = out_q;

  assign fwd_data_out.valid  = valid_q && out_q.wr_Rd;
  assign fwd_data_out.Rd     = out_q.Rd;
  assign fwd_data_out.RdData = out_q.RdData;

  assign unused_fields = ^{data_in.rd.regs.Rs1, data_in.rd.regs.Rs2, data_in.ipd.instruction};

endmodule

// File: tb/tb_alu_functional_unit.sv
// Scoreboard bench for alu_functional_unit: expected results queued at drive time.
module tb_alu_functional_unit;
  import cpu_params_RV::*;

  logic       clk_in   = 1'b0;
  logic       reset_in = 1'b0;
  FU_Data_In  data_in  = '0;
  logic       valid_in = 1'b0;
  logic       rdy_in   = 1'b1;
  logic       rdy_out;
  FU_Data_Out data_out;
  logic       valid_out;
  FWD_Data    fwd_data_out;

  FU_Data_Out exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  alu_functional_unit dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .rdy_out      (rdy_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .rdy_in       (rdy_in),
    .fwd_data_out (fwd_data_out)
  );

  function automatic FU_Data_In mk_op(
    input logic [ALU_FSZ-1:0] f, input logic [1:0] sx, input logic sy,
    input logic [RSZ-1:0] rs1, input logic [RSZ-1:0] rs2, input logic [RSZ-1:0] imm,
    input logic [PC_SZ-1:0] pc, input logic [GPR_ASZ-1:0] rd, input logic wr,
    input logic [TAG_SZ-1:0] tag);
    FU_Data_In d;
    d                    = '0;
    d.tag                = tag;
    d.md.F               = f;
    d.md.Sel_x           = sx;
    d.md.Sel_y           = sy;
    d.md.imm             = imm;
    d.rd.regs.Rs1        = GPR_ASZ'(1);
    d.rd.regs.Rs2        = GPR_ASZ'(2);
    d.rd.regs.Rd         = rd;
    d.rd.regs_rw.wr_Rd   = wr;
    d.ipd.instruction    = 32'h0000_0013;
    d.ipd.pc             = pc;
    d.Rs1Data            = rs1;
    d.Rs2Data            = rs2;
    return d;
  endfunction

  // Drive one op and queue the result the writeback port must show for it
  task automatic issue(input FU_Data_In d, input logic [RSZ-1:0] res);
    FU_Data_Out e;
    e.tag    = d.tag;
    e.Rd     = d.rd.regs.Rd;
    e.wr_Rd  = d.rd.regs_rw.wr_Rd && (d.rd.regs.Rd != '0);
    e.RdData = res;
    exp_q.push_back(e);
    data_in  = d;
    valid_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    rdy_in   = 1'b1;
    issue(mk_op(ALU_ADD, SEL_X_RS1, SEL_Y_RS2, 32'd1, 32'd2, '0, '0, 5'd7, 1'b1, 4'h5), 32'd3);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    tests_run++;
    if (fwd_data_out.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_data_out.valid); end
    tests_run++;
    if (rdy_out !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy_out: got %b want 1", rdy_out); end
    tests_run++;
    if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", data_out); end
    reset_in = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_release_valid: got %b want 0", valid_out); end
  endtask

  task automatic test_add_imm();
    FU_Data_Out e;
    // imm is the sign-extended form of 12-bit 0xFFF (-1)
    issue(mk_op(ALU_ADD, SEL_X_RS1, SEL_Y_IMM, 32'h5, 32'h0, 32'hFFFF_FFFF, '0, 5'd3, 1'b1, 4'h1), 32'h4);
    @(negedge clk_in);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %b want 1", valid_out); end
    tests_run++;
    if (data_out !== e) begin tests_failed++; $display("FAIL add_data: got %h want %h", data_out, e); end
    tests_run++;
    if (fwd_data_out !== {1'b1, 5'd3, 32'h4}) begin
      tests_failed++; $display("FAIL add_fwd: got v=%b rd=%0d d=%h want v=1 rd=3 d=4",
                               fwd_data_out.valid, fwd_data_out.Rd, fwd_data_out.RdData);
    end
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0 || data_out.wr_Rd !== 1'b0 || data_out.RdData !== 32'h4) begin
      tests_failed++; $display("FAIL add_drain: got v=%b wr=%b d=%h want v=0 wr=0 d=4",
                               valid_out, data_out.wr_Rd, data_out.RdData);
    end
    tests_run++;
    if (fwd_data_out.valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain_fwd: got %b want 0", fwd_data_out.valid); end
  endtask

  task automatic test_func_sweep();
    localparam int N = 12;
    logic [ALU_FSZ-1:0] fs [N] = '{ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_ADD,
                                   ALU_SLL, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_Y, ALU_FSZ'(12)};
    logic [RSZ-1:0] ex [N] = '{32'h7FFF_FFFF, 32'hC000_0000, 32'h4000_0000, 32'h1, 32'h0,
                               32'h8000_0001, 32'h0, 32'h8000_0001, 32'h8000_0001, 32'h0,
                               32'h1, 32'h0};
    FU_Data_Out e;
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (valid_out !== 1'b1 || data_out !== e) begin
          tests_failed++; $display("FAIL sweep_%0d: got v=%b data=%h want v=1 data=%h", i - 1, valid_out, data_out, e);
        end
        tests_run++;
        if (fwd_data_out.valid !== 1'b1 || fwd_data_out.RdData !== ex[i-1]) begin
          tests_failed++; $display("FAIL sweep_fwd_%0d: got v=%b d=%h want v=1 d=%h",
                                   i - 1, fwd_data_out.valid, fwd_data_out.RdData, ex[i-1]);
        end
      end
      if (i < N) begin
        issue(mk_op(fs[i], SEL_X_RS1, SEL_Y_RS2, 32'h8000_0000, 32'h1, '0, '0,
                    GPR_ASZ'(i + 1), 1'b1, TAG_SZ'(i)), ex[i]);
        @(negedge clk_in);
      end else begin
        valid_in = 1'b0;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic test_lui_pc4();
    FU_Data_Out e;
    issue(mk_op(ALU_PASS_Y, SEL_X_ZERO, SEL_Y_IMM, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, '0, 5'd5, 1'b1, 4'h2), 32'h1234_5000);
    @(negedge clk_in);
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin tests_failed++; $display("FAIL lui: got %h want %h", data_out, e); end
    // Sel_x points at Rs1 on purpose: the link value must still come from the pc
    issue(mk_op(ALU_ADD_PC4, SEL_X_RS1, SEL_Y_RS2, 32'h777, 32'h9, '0, 32'h100, 5'd1, 1'b1, 4'h3), 32'h104);
    @(negedge clk_in);
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin tests_failed++; $display("FAIL add_pc4: got %h want %h", data_out, e); end
    issue(mk_op(ALU_ADD, SEL_X_PC, SEL_Y_RS2, 32'h777, 32'h10, '0, 32'h200, 5'd9, 1'b1, 4'h4), 32'h210);
    @(negedge clk_in);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin tests_failed++; $display("FAIL sel_x_pc: got %h want %h", data_out, e); end
    @(negedge clk_in);
  endtask

  task automatic test_x0();
    FU_Data_Out e;
    issue(mk_op(ALU_ADD, SEL_X_RS1, SEL_Y_RS2, 32'h7, 32'h8, '0, '0, 5'd0, 1'b1, 4'h6), 32'hF);
    @(negedge clk_in);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin tests_failed++; $display("FAIL x0_data: got %h want %h", data_out, e); end
    tests_run++;
    if (data_out.wr_Rd !== 1'b0 || fwd_data_out.valid !== 1'b0) begin
      tests_failed++; $display("FAIL x0_write: got wr=%b fwd=%b want wr=0 fwd=0", data_out.wr_Rd, fwd_data_out.valid);
    end
    @(negedge clk_in);
  endtask

  task automatic test_back_to_back();
    FU_Data_Out e;
    rdy_in = 1'b0;
    issue(mk_op(ALU_SUB, SEL_X_RS1, SEL_Y_RS2, 32'd10, 32'd3, '0, '0, 5'd4, 1'b1, 4'hA), 32'd7);
    @(negedge clk_in);
    issue(mk_op(ALU_AND, SEL_X_RS1, SEL_Y_IMM, 32'hF0F0, 32'h0, 32'h0FF0, '0, 5'd6, 1'b1, 4'hB), 32'h00F0);
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (valid_out !== 1'b1 || data_out !== exp_q[0]) begin
        tests_failed++; $display("FAIL stall_hold_%0d: got v=%b data=%h want v=1 data=%h", c, valid_out, data_out, exp_q[0]);
      end
      tests_run++;
      if (rdy_out !== 1'b0) begin tests_failed++; $display("FAIL stall_rdy_out_%0d: got %b want 0", c, rdy_out); end
      @(negedge clk_in);
    end
    rdy_in = 1'b1;
    #1;
    tests_run++;
    if (rdy_out !== 1'b1) begin tests_failed++; $display("FAIL release_rdy_out: got %b want 1", rdy_out); end
    void'(exp_q.pop_front());
    @(negedge clk_in);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin
      tests_failed++; $display("FAIL second_op: got v=%b data=%h want v=1 data=%h", valid_out, data_out, e);
    end
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0 || data_out.wr_Rd !== 1'b0 || data_out.RdData !== 32'h00F0 || data_out.tag !== 4'hB) begin
      tests_failed++; $display("FAIL final_drain: got v=%b wr=%b d=%h tag=%h want v=0 wr=0 d=f0 tag=b",
                               valid_out, data_out.wr_Rd, data_out.RdData, data_out.tag);
    end
  endtask

  task automatic test_reset_mid();
    FU_Data_Out e;
    rdy_in = 1'b0;
    issue(mk_op(ALU_OR, SEL_X_RS1, SEL_Y_RS2, 32'h1, 32'h2, '0, '0, 5'd2, 1'b1, 4'hC), 32'h3);
    @(negedge clk_in);
    valid_in = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== e) begin tests_failed++; $display("FAIL mid_held: got %h want %h", data_out, e); end
    reset_in = 1'b0;
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0 || fwd_data_out.valid !== 1'b0 || data_out !== '0) begin
      tests_failed++; $display("FAIL mid_reset: got v=%b fwd=%b data=%h want all 0", valid_out, fwd_data_out.valid, data_out);
    end
    reset_in = 1'b1;
    rdy_in   = 1'b1;
    @(negedge clk_in);
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL mid_after: got %b want 0", valid_out); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_add_imm();
    test_func_sweep();
    test_lui_pc4();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
